// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings,
// port indices and the active-low memory strobe levels.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StAccess   = 2'b01,
    StComplete = 2'b10
  } arb_state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortLdr = 1'b1;

  localparam logic MemEnOn    = 1'b0;
  localparam logic MemWrWrite = 1'b0;

endpackage

// File: rtl/memory_port_arbiter_priority_pick.sv
// Combinational winner select between the CPU and loader requests.
// ARB_ROUND_ROBIN_EN: on a tie the port not served last wins; otherwise CPU has priority.
module memory_port_arbiter_priority_pick
  import memory_port_arbiter_pkg::*;
(
  input  logic cpu_req_i,
  input  logic ldr_req_i,
  input  logic last_i,
  output logic valid_o,
  output logic port_o
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    valid_o = cpu_req_i | ldr_req_i;
    port_o  = PortCpu;
`ifdef ARB_ROUND_ROBIN_EN
    if (cpu_req_i && ldr_req_i) begin
      port_o = ~last_i;
    end else if (ldr_req_i) begin
      port_o = PortLdr;
    end
`else
    if (!cpu_req_i && ldr_req_i) begin
      port_o = PortLdr;
    end
`endif
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one synchronous memory between the CPU sequencer and the loader port.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of fixed CPU priority.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CPU_Req,
  input  logic                 CPU_Wr,
  input  logic [AddrWidth-1:0] CPU_Addr,
  input  logic [DataWidth-1:0] CPU_WData,
  output logic                 CPU_Gnt,
  output logic                 CPU_Done,
  input  logic                 LDR_Req,
  input  logic                 LDR_Wr,
  input  logic [AddrWidth-1:0] LDR_Addr,
  input  logic [DataWidth-1:0] LDR_WData,
  output logic                 LDR_Gnt,
  output logic                 LDR_Done,
  output logic [DataWidth-1:0] RData,
  output logic                 MEM_En,
  output logic                 MEM_Wr,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_WData,
  input  logic [DataWidth-1:0] MEM_RData,
  output logic                 Busy
);

  arb_state_e           state_q, state_d;
  logic                 winner_q, winner_d;
  logic                 last_q, last_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 cpu_gnt_q, cpu_gnt_d, ldr_gnt_q, ldr_gnt_d;
  logic                 cpu_done_q, cpu_done_d, ldr_done_q, ldr_done_d;
  logic                 pick_valid, pick_port;

  memory_port_arbiter_priority_pick u_pick (
    .cpu_req_i (CPU_Req),
    .ldr_req_i (LDR_Req),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .port_o    (pick_port)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    mem_en_d    = ~MemEnOn;
    mem_wr_d    = ~MemWrWrite;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_gnt_d   = 1'b0;
    ldr_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    ldr_done_d  = 1'b0;
    unique case (state_q)
      // COMPLETE re-arbitrates exactly like IDLE, giving one access per two cycles.
      StIdle, StComplete: begin
        if (pick_valid) begin
          state_d  = StAccess;
          winner_d = pick_port;
          last_d   = pick_port;
          mem_en_d = MemEnOn;
          if (pick_port == PortLdr) begin
            mem_wr_d    = LDR_Wr ? MemWrWrite : ~MemWrWrite;
            mem_addr_d  = LDR_Addr;
            mem_wdata_d = LDR_WData;
            ldr_gnt_d   = 1'b1;
          end else begin
            mem_wr_d    = CPU_Wr ? MemWrWrite : ~MemWrWrite;
            mem_addr_d  = CPU_Addr;
            mem_wdata_d = CPU_WData;
            cpu_gnt_d   = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        state_d    = StComplete;
        cpu_gnt_d  = (winner_q == PortCpu);
        ldr_gnt_d  = (winner_q == PortLdr);
        cpu_done_d = (winner_q == PortCpu);
        ldr_done_d = (winner_q == PortLdr);
      end
      default: state_d = StIdle;
    endcase
  end

  // A reset while in ACCESS still lets the memory sample the presented cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      winner_q    <= PortCpu;
      last_q      <= PortCpu;
      mem_en_q    <= ~MemEnOn;
      mem_wr_q    <= ~MemWrWrite;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      ldr_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      ldr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      ldr_gnt_q   <= ldr_gnt_d;
      cpu_done_q  <= cpu_done_d;
      ldr_done_q  <= ldr_done_d;
    end
  end

  assign CPU_Gnt   = cpu_gnt_q;
  assign LDR_Gnt   = ldr_gnt_q;
  assign CPU_Done  = cpu_done_q;
  assign LDR_Done  = ldr_done_q;
  assign MEM_En    = mem_en_q;
  assign MEM_Wr    = mem_wr_q;
  assign MEM_Addr  = mem_addr_q;
  assign MEM_WData = mem_wdata_q;
  assign RData     = MEM_RData;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model (access = 2 cycles, policy by ARB_ROUND_ROBIN_EN).
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, cpu_gnt, cpu_done;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        ldr_req, ldr_wr, ldr_gnt, ldr_done;
  logic [7:0]  ldr_addr;
  logic [15:0] ldr_wdata;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, busy;
  logic [7:0]  mem_addr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        init_mem = 1'b0;
  logic        model_last;
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  always #5 clk = ~clk;

  memory_port_arbiter #(.DataWidth(16), .AddrWidth(8)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .CPU_Req   (cpu_req),
    .CPU_Wr    (cpu_wr),
    .CPU_Addr  (cpu_addr),
    .CPU_WData (cpu_wdata),
    .CPU_Gnt   (cpu_gnt),
    .CPU_Done  (cpu_done),
    .LDR_Req   (ldr_req),
    .LDR_Wr    (ldr_wr),
    .LDR_Addr  (ldr_addr),
    .LDR_WData (ldr_wdata),
    .LDR_Gnt   (ldr_gnt),
    .LDR_Done  (ldr_done),
    .RData     (rdata),
    .MEM_En    (mem_en),
    .MEM_Wr    (mem_wr),
    .MEM_Addr  (mem_addr),
    .MEM_WData (mem_wdata),
    .MEM_RData (mem_rdata),
    .Busy      (busy)
  );

  function automatic logic [15:0] init_word(int i);
    if (i == 16) return 16'hA5A5;
    return 16'(i * 257) ^ 16'h3C5A;
  endfunction

  // Synchronous memory: samples on the edge where MEM_En is low.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_en == 1'b0) begin
      if (mem_wr == 1'b0) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  function automatic logic pick(logic cpu_r, logic ldr_r, logic last);
    if (cpu_r && ldr_r) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return ldr_r;
  endfunction

  function automatic logic [1:0] onehot(logic port);
    return port ? 2'b01 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    init_mem = 1'b1; reset = 1'b1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h55; cpu_wdata = 16'hFFFF;
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 8'hAA; ldr_wdata = 16'h5555;
    tick(); tick();
    n_tests++; if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done} !== 4'b0) begin
      n_fail++; $display("FAIL rst_gnt_done: got %b expected 0000", {cpu_gnt, ldr_gnt, cpu_done, ldr_done}); end
    n_tests++; if ({mem_en, mem_wr, busy} !== 3'b110) begin
      n_fail++; $display("FAIL rst_en_wr_busy: got %b expected 110", {mem_en, mem_wr, busy}); end
    n_tests++; if ({mem_addr, mem_wdata} !== 24'h0) begin
      n_fail++; $display("FAIL rst_addr_wdata: got %h expected 000000", {mem_addr, mem_wdata}); end
    cpu_req = 1'b0; ldr_req = 1'b0; reset = 1'b0; init_mem = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_last = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'(($urandom));
    tick();
    n_tests++; if ({cpu_gnt, ldr_gnt, mem_en, mem_wr, cpu_done} !== 5'b10010) begin
      n_fail++; $display("FAIL rd_access: got %b expected 10010", {cpu_gnt, ldr_gnt, mem_en, mem_wr, cpu_done}); end
    n_tests++; if (mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL rd_addr: got %h expected 10", mem_addr); end
    tick();
    n_tests++; if ({cpu_done, cpu_gnt, mem_en, mem_wr} !== 4'b1111) begin
      n_fail++; $display("FAIL rd_complete: got %b expected 1111", {cpu_done, cpu_gnt, mem_en, mem_wr}); end
    n_tests++; if (rdata !== ref_mem[16]) begin
      n_fail++; $display("FAIL rd_data: got %h expected %h", rdata, ref_mem[16]); end
    cpu_req = 1'b0; model_last = 1'b0;
    tick();
    n_tests++; if ({cpu_gnt, cpu_done, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rd_idle: got %b expected 000", {cpu_gnt, cpu_done, busy}); end
  endtask

  task automatic test_ldr_write_read();
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 8'h20; ldr_wdata = 16'h1234;
    tick();
    n_tests++; if ({cpu_gnt, ldr_gnt, mem_wr} !== 3'b010) begin
      n_fail++; $display("FAIL wr_access: got %b expected 010", {cpu_gnt, ldr_gnt, mem_wr}); end
    n_tests++; if (mem_wdata !== 16'h1234) begin
      n_fail++; $display("FAIL wr_wdata: got %h expected 1234", mem_wdata); end
    tick();
    n_tests++; if ({ldr_done, mem_wr, cpu_done} !== 3'b110) begin
      n_fail++; $display("FAIL wr_complete: got %b expected 110", {ldr_done, mem_wr, cpu_done}); end
    ldr_req = 1'b0; ref_mem[32] = 16'h1234;
    tick();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h20;
    tick(); tick();
    n_tests++; if ({cpu_done, rdata} !== {1'b1, ref_mem[32]}) begin
      n_fail++; $display("FAIL wr_readback: got %b/%h expected 1/%h", cpu_done, rdata, ref_mem[32]); end
    cpu_req = 1'b0; model_last = 1'b0;
    tick();
  endtask

  task automatic test_drop_after_gnt();
    ldr_req = 1'b1; ldr_wr = 1'b0; ldr_addr = 8'h20;
    tick();
    n_tests++; if (ldr_gnt !== 1'b1) begin
      n_fail++; $display("FAIL drop_gnt: got %b expected 1", ldr_gnt); end
    ldr_req = 1'b0;
    tick();
    n_tests++; if ({ldr_done, rdata} !== {1'b1, ref_mem[32]}) begin
      n_fail++; $display("FAIL drop_done: got %b/%h expected 1/%h", ldr_done, rdata, ref_mem[32]); end
    tick();
    n_tests++; if ({ldr_done, ldr_gnt, busy} !== 3'b000) begin
      n_fail++; $display("FAIL drop_idle: got %b expected 000", {ldr_done, ldr_gnt, busy}); end
    model_last = 1'b1;
  endtask

  task automatic test_contention();
    logic w;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h50;
    ldr_req = 1'b1; ldr_wr = 1'b0; ldr_addr = 8'h51;
    tick();
    for (int i = 0; i < 8; i++) begin
      w = pick(1'b1, 1'b1, model_last);
      model_last = w;
      n_tests++; if ({cpu_gnt, ldr_gnt} !== onehot(w)) begin
        n_fail++; $display("FAIL cont_gnt%0d: got %b expected %b", i, {cpu_gnt, ldr_gnt}, onehot(w)); end
      tick();
      n_tests++; if ({cpu_done, ldr_done} !== onehot(w)) begin
        n_fail++; $display("FAIL cont_done%0d: got %b expected %b", i, {cpu_done, ldr_done}, onehot(w)); end
      if (i == 7) begin cpu_req = 1'b0; ldr_req = 1'b0; end
      tick();
    end
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL cont_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_in_access();
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 8'h30; ldr_wdata = 16'hBEEF;
    tick();
    reset = 1'b1; ldr_req = 1'b0;
    tick();
    n_tests++; if ({ldr_done, ldr_gnt, busy, mem_en} !== 4'b0001) begin
      n_fail++; $display("FAIL rsta_state: got %b expected 0001", {ldr_done, ldr_gnt, busy, mem_en}); end
    n_tests++; if (mem[48] !== 16'hBEEF) begin
      n_fail++; $display("FAIL rsta_commit: got %h expected beef", mem[48]); end
    reset = 1'b0; ref_mem[48] = 16'hBEEF; model_last = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h30;
    tick(); tick();
    n_tests++; if ({cpu_done, rdata} !== {1'b1, ref_mem[48]}) begin
      n_fail++; $display("FAIL rsta_readback: got %b/%h expected 1/%h", cpu_done, rdata, ref_mem[48]); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_random(int ncyc);
    logic        pend [2];
    logic        r_wr [2];
    logic [7:0]  r_addr [2];
    logic [15:0] r_wdata [2];
    logic [1:0]  e_gnt [4];
    logic [1:0]  e_done [4];
    logic        e_busy [4];
    logic        e_isrd [4];
    logic [15:0] e_rd [4];
    logic        w;
    int          next_dec, s, s1, s2;
    next_dec = 0;
    for (int p = 0; p < 2; p++) pend[p] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e_gnt[k] = '0; e_done[k] = '0; e_busy[k] = 1'b0; e_isrd[k] = 1'b0; e_rd[k] = '0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      s = cyc % 4;
      n_tests++; if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, busy} !== {e_gnt[s], e_done[s], e_busy[s]}) begin
        n_fail++; $display("FAIL rnd_ctl@%0d: got %b expected %b", cyc,
          {cpu_gnt, ldr_gnt, cpu_done, ldr_done, busy}, {e_gnt[s], e_done[s], e_busy[s]}); end
      if (e_done[s] != 2'b00 && e_isrd[s]) begin
        n_tests++; if (rdata !== e_rd[s]) begin
          n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, rdata, e_rd[s]); end
      end
      for (int p = 0; p < 2; p++) if (e_done[s] == onehot(1'(p))) pend[p] = 1'b0;
      e_gnt[s] = '0; e_done[s] = '0; e_busy[s] = 1'b0; e_isrd[s] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1'b1;
          r_wr[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = 8'h40 + 8'($urandom_range(0, 15));
          r_wdata[p] = 16'($urandom);
        end
      end
      cpu_req = pend[0]; cpu_wr = r_wr[0]; cpu_addr = r_addr[0]; cpu_wdata = r_wdata[0];
      ldr_req = pend[1]; ldr_wr = r_wr[1]; ldr_addr = r_addr[1]; ldr_wdata = r_wdata[1];
      if (cyc + 1 >= next_dec && (pend[0] || pend[1])) begin
        w  = pick(pend[0], pend[1], model_last);
        s1 = (cyc + 1) % 4;
        s2 = (cyc + 2) % 4;
        e_gnt[s1] = onehot(w); e_gnt[s2] = onehot(w);
        e_busy[s1] = 1'b1; e_busy[s2] = 1'b1;
        e_done[s2] = onehot(w);
        e_isrd[s2] = !r_wr[w];
        e_rd[s2]   = ref_mem[r_addr[w]];
        if (r_wr[w]) ref_mem[r_addr[w]] = r_wdata[w];
        model_last = w;
        next_dec   = cyc + 3;
      end
      tick();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_ldr_write_read();
    test_drop_after_gnt();
    test_contention();
    test_reset_in_access();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
